// File: rtl/motor_pkg.sv
// Shared motor-drive definitions: bridge pin patterns, guard FSM states and command decode.
package motor_pkg;

  localparam logic [3:0] CMD_OFF   = 4'b0000;
  localparam logic [3:0] CMD_FWD   = 4'b0110;
  localparam logic [3:0] CMD_REV   = 4'b1001;
  localparam logic [3:0] CMD_BRAKE = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DRIVE_FWD,
    ST_DRIVE_REV,
    ST_FAULT
  } guard_state_t;

  typedef enum logic [1:0] {
    DEC_OFF,
    DEC_FWD,
    DEC_REV,
    DEC_ILLEGAL
  } cmd_dec_t;

  function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
    cmd_dec_t dec;
    case (cmd)
      CMD_OFF: dec = DEC_OFF;
      CMD_FWD: dec = DEC_FWD;
      CMD_REV: dec = DEC_REV;
      default: dec = DEC_ILLEGAL;
    endcase
    return dec;
  endfunction

  // Brake (1111) is deliberately not a drive pattern: it counts as off time.
  function automatic logic is_drive(input logic [3:0] pins);
    return (pins == CMD_FWD) || (pins == CMD_REV);
  endfunction

endpackage

// File: rtl/hbridge_guard_if.sv
// Command/status bundle between the PWM controller (master) and the bridge guard (slave).
interface hbridge_guard_if;

  logic [3:0] in_cmd;
  logic       fault_clr;
  logic [3:0] IN;
  logic       fault;
  logic       busy;
  logic       dir;

  modport master (
    output in_cmd,
    output fault_clr,
    input  IN,
    input  fault,
    input  busy,
    input  dir
  );

  modport slave (
    input  in_cmd,
    input  fault_clr,
    output IN,
    output fault,
    output busy,
    output dir
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; count_next_o is the value the register
// will take at the next edge when no clear is applied.
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_next_o
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_next_o = count_q;
    if (inc_i && (count_q < MAX_C)) begin
      count_next_o = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_next_o;
    end
  end

endmodule

// File: rtl/hbridge_guard.sv
// H-bridge safety gate: dead time before any drive, coast time before reversal, latched fault.
// Optional fast brake during a reversal wait: define HBRIDGE_GUARD_BRAKE_EN.
module hbridge_guard #(
  parameter int DEAD_CYCLES  = 100,
  parameter int COAST_CYCLES = 100000
) (
  input  logic           clk,
  input  logic           reset,
  hbridge_guard_if.slave bus
);

  import motor_pkg::*;

  localparam int CW = $clog2(COAST_CYCLES + 1);
  localparam logic [CW-1:0] DEAD_C  = CW'(DEAD_CYCLES);
  localparam logic [CW-1:0] COAST_C = CW'(COAST_CYCLES);

  logic [3:0]   cmd_q;
  cmd_dec_t     cmd_dec;
  guard_state_t state_q;
  guard_state_t state_d;
  logic [3:0]   in_q;
  logic [3:0]   in_d;
  logic         fault_q;
  logic         busy_q;
  logic         last_dir_q;
  logic         last_valid_q;
  logic [CW-1:0] off_next;
  logic         req_dir;
  logic         gate_ok;
  logic         drive_entry;

  // Captured every cycle, reset included, so a command held through reset is seen at once.
  always_ff @(posedge clk) begin
    cmd_q <= bus.in_cmd;
  end

  assign cmd_dec = decode_cmd(cmd_q);
  assign req_dir = (cmd_dec == DEC_REV);

  // off_next includes the current off cycle, so the pins see exactly DEAD/COAST cycles of off.
  sat_counter #(
    .WIDTH (CW),
    .MAX   (COAST_CYCLES)
  ) u_off_count (
    .clk          (clk),
    .reset        (reset),
    .inc_i        (!is_drive(in_q)),
    .clr_i        (drive_entry),
    .count_next_o (off_next)
  );

  assign gate_ok = (off_next >= DEAD_C) &&
                   (!last_valid_q || (req_dir == last_dir_q) || (off_next >= COAST_C));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_WAIT: begin
        case (cmd_dec)
          DEC_OFF:          state_d = ST_IDLE;
          DEC_FWD, DEC_REV: state_d = gate_ok ? (req_dir ? ST_DRIVE_REV : ST_DRIVE_FWD) : ST_WAIT;
          default:          state_d = ST_FAULT;
        endcase
      end
      ST_DRIVE_FWD: begin
        case (cmd_dec)
          DEC_OFF: state_d = ST_IDLE;
          DEC_FWD: state_d = ST_DRIVE_FWD;
          DEC_REV: state_d = ST_WAIT;
          default: state_d = ST_FAULT;
        endcase
      end
      ST_DRIVE_REV: begin
        case (cmd_dec)
          DEC_OFF: state_d = ST_IDLE;
          DEC_REV: state_d = ST_DRIVE_REV;
          DEC_FWD: state_d = ST_WAIT;
          default: state_d = ST_FAULT;
        endcase
      end
      ST_FAULT: begin
        if (bus.fault_clr && (cmd_dec == DEC_OFF)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign drive_entry = (state_d == ST_DRIVE_FWD) || (state_d == ST_DRIVE_REV);

  always_comb begin
    case (state_d)
      ST_DRIVE_FWD: in_d = CMD_FWD;
      ST_DRIVE_REV: in_d = CMD_REV;
      default:      in_d = CMD_OFF;
    endcase
`ifdef HBRIDGE_GUARD_BRAKE_EN
    if ((state_d == ST_WAIT) && last_valid_q && (req_dir != last_dir_q) &&
        (off_next >= DEAD_C)) begin
      in_d = CMD_BRAKE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      in_q         <= CMD_OFF;
      fault_q      <= 1'b0;
      busy_q       <= 1'b0;
      last_dir_q   <= 1'b0;
      last_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      fault_q <= (state_d == ST_FAULT);
      busy_q  <= (state_d == ST_WAIT);
      if (drive_entry) begin
        last_dir_q   <= (state_d == ST_DRIVE_REV);
        last_valid_q <= 1'b1;
      end
    end
  end

  assign bus.IN    = in_q;
  assign bus.fault = fault_q;
  assign bus.busy  = busy_q;
  assign bus.dir   = last_dir_q;

endmodule

// File: tb/tb_hbridge_guard.sv
// Directed-vector bench for hbridge_guard; per-cycle expected pins/flags go through a scoreboard queue.
module tb_hbridge_guard;

  import motor_pkg::*;

  localparam int DEAD  = 4;
  localparam int COAST = 20;

`ifdef HBRIDGE_GUARD_BRAKE_EN
  localparam logic [3:0] WAIT_PINS = 4'b1111;
`else
  localparam logic [3:0] WAIT_PINS = 4'b0000;
`endif

  typedef struct packed {
    logic [3:0] pins;
    logic       fault;
    logic       busy;
    logic       dir;
  } exp_t;

  typedef struct {
    logic       rst_n;
    logic [3:0] cmd;
    logic       clr;
    int         n;
    exp_t       exp;
  } row_t;

  logic clk = 1'b0;
  logic reset;

  hbridge_guard_if bus();

  hbridge_guard #(
    .DEAD_CYCLES  (DEAD),
    .COAST_CYCLES (COAST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  row_t rows[$];
  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   mon_cyc = 0;

  task automatic add(input logic r, input logic [3:0] c, input logic cl, input int n,
                     input logic [3:0] p, input logic f, input logic b, input logic d);
    row_t rw;
    rw.rst_n     = r;
    rw.cmd       = c;
    rw.clr       = cl;
    rw.n         = n;
    rw.exp.pins  = p;
    rw.exp.fault = f;
    rw.exp.busy  = b;
    rw.exp.dir   = d;
    rows.push_back(rw);
  endtask

  task automatic chk(input string name, input int cyc, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b required %b", name, cyc, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents its registered outputs, pop and compare.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("IN",    mon_cyc, bus.IN,                 mon_e.pins);
        chk("fault", mon_cyc, {3'b000, bus.fault},    {3'b000, mon_e.fault});
        chk("busy",  mon_cyc, {3'b000, bus.busy},     {3'b000, mon_e.busy});
        chk("dir",   mon_cyc, {3'b000, bus.dir},      {3'b000, mon_e.dir});
        mon_cyc++;
      end
    end
  end

  initial begin
    reset         = 1'b0;
    bus.in_cmd    = CMD_OFF;
    bus.fault_clr = 1'b0;

    // Expected outputs in a row are those visible during that row's cycles (inputs lead by 2).
    // Reset then FWD held: off for 4 cycles after capture, busy during hold-off.
    add(0, CMD_FWD, 0, 1, 4'b0000, 0, 0, 0);
    add(1, CMD_FWD, 0, 1, 4'b0000, 0, 0, 0);
    add(1, CMD_FWD, 0, 3, 4'b0000, 0, 1, 0);
    add(1, CMD_FWD, 0, 3, 4'b0110, 0, 0, 0);
    // Two-cycle OFF pulses stretch to four cycles at the pins.
    for (int p = 0; p < 2; p++) begin
      add(1, CMD_OFF, 0, 2, 4'b0110, 0, 0, 0);
      add(1, CMD_FWD, 0, 2, 4'b0000, 0, 0, 0);
      add(1, CMD_FWD, 0, 2, 4'b0000, 0, 1, 0);
      add(1, CMD_FWD, 0, 2, 4'b0110, 0, 0, 0);
    end
    // Immediate reversal: 20 cycles off (brake on cycles 5..20 when enabled), then REV.
    add(1, CMD_REV, 0, 2,  4'b0110,  0, 0, 0);
    add(1, CMD_REV, 0, 4,  4'b0000,  0, 1, 0);
    add(1, CMD_REV, 0, 16, WAIT_PINS, 0, 1, 0);
    add(1, CMD_REV, 0, 2,  4'b1001,  0, 0, 1);
    // Illegal command in DRIVE_REV, clear refused while illegal, accepted with OFF.
    add(1, CMD_BRAKE, 0, 2, 4'b1001, 0, 0, 1);
    add(1, CMD_BRAKE, 0, 2, 4'b0000, 1, 0, 1);
    add(1, CMD_BRAKE, 1, 2, 4'b0000, 1, 0, 1);
    add(1, CMD_OFF,   0, 2, 4'b0000, 1, 0, 1);
    add(1, CMD_OFF,   1, 1, 4'b0000, 1, 0, 1);
    add(1, CMD_OFF,   0, 2, 4'b0000, 0, 0, 1);
    // FWD after REV: fault time counts toward coast, drive once 20 off cycles accumulate.
    add(1, CMD_FWD, 0, 2, 4'b0000,   0, 0, 1);
    add(1, CMD_FWD, 0, 9, WAIT_PINS, 0, 1, 1);
    add(1, CMD_FWD, 0, 2, 4'b0110,   0, 0, 0);
    // One-cycle reset mid-drive: pins off at once, 0110 again four cycles after the reset edge.
    add(0, CMD_FWD, 0, 1, 4'b0110, 0, 0, 0);
    add(1, CMD_FWD, 0, 1, 4'b0000, 0, 0, 0);
    add(1, CMD_FWD, 0, 3, 4'b0000, 0, 1, 0);
    add(1, CMD_FWD, 0, 2, 4'b0110, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    foreach (rows[i]) begin
      $display("row %0d: rst_n=%b cmd=%b clr=%b cycles=%0d exp IN=%b fault=%b busy=%b dir=%b",
               i, rows[i].rst_n, rows[i].cmd, rows[i].clr, rows[i].n,
               rows[i].exp.pins, rows[i].exp.fault, rows[i].exp.busy, rows[i].exp.dir);
      for (int k = 0; k < rows[i].n; k++) begin
        reset         = rows[i].rst_n;
        bus.in_cmd    = rows[i].cmd;
        bus.fault_clr = rows[i].clr;
        sb_q.push_back(rows[i].exp);
        @(posedge clk);
        #1;
      end
    end

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) begin
      @(negedge clk);
    end
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left required 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
